// File: rtl/axi_slave_cmd_arb_pkg.sv
// Shared types and widths for the AXI slave command arbiter.
package axi_slave_cmd_arb_pkg;

    localparam int unsigned ADDR_W   = 64;
    localparam int unsigned LEN_W    = 8;
    localparam int unsigned SIZE_W   = 3;
    localparam int unsigned BURST_W  = 2;
    localparam int unsigned STAT_W   = 32;
    localparam int unsigned CREDIT_W = 8;
    localparam int unsigned STREAK_W = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_e;

    // Fixed-width AXI address-channel fields carried with every command
    typedef struct packed {
        logic [ADDR_W-1:0]  addr;
        logic [LEN_W-1:0]   len;
        logic [SIZE_W-1:0]  size;
        logic [BURST_W-1:0] burst;
    } axi_fields_t;

endpackage

// File: rtl/axi_slave_cmd_arb_sel.sv
// Write/read winner select with a bounded write streak so reads are not starved.
module axi_slave_cmd_arb_sel
    import axi_slave_cmd_arb_pkg::*;
#(
    parameter int unsigned WR_WEIGHT = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic wr_pend,
    input  logic rd_pend,
    input  logic grant,
    output logic pick_wr_c
);

    localparam logic [STREAK_W-1:0] WEIGHT_V = STREAK_W'(WR_WEIGHT);

    logic [STREAK_W-1:0] wr_streak;

    assign pick_wr_c = wr_pend && (!rd_pend || (wr_streak != WEIGHT_V));

    // Streak only grows while a read is actually waiting behind the writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_streak <= '0;
        end else if (grant) begin
            if (!pick_wr_c || !rd_pend) begin
                wr_streak <= '0;
            end else if (wr_streak != WEIGHT_V) begin
                wr_streak <= wr_streak + STREAK_W'(1);
            end
        end
    end

endmodule

// File: rtl/axi_slave_cmd_arb.sv
// Merges write/read command FIFOs into one credited downstream command stream.
// Optional grant statistics enabled by defining AXI_SLAVE_CMD_ARB_STATS_EN.
module axi_slave_cmd_arb
    import axi_slave_cmd_arb_pkg::*;
#(
    parameter int unsigned IDW       = 3,
    parameter int unsigned CTXW      = 9,
    parameter int unsigned WR_WEIGHT = 2,
    parameter int unsigned CREDITS   = 16
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                wr_cf_empty,
    output logic                wr_cf_rd_en,
    input  logic [IDW-1:0]      wr_cf_id,
    input  logic [ADDR_W-1:0]   wr_cf_addr,
    input  logic [LEN_W-1:0]    wr_cf_len,
    input  logic [SIZE_W-1:0]   wr_cf_size,
    input  logic [BURST_W-1:0]  wr_cf_burst,
    input  logic [CTXW-1:0]     wr_cf_user,

    input  logic                rd_cf_empty,
    output logic                rd_cf_rd_en,
    input  logic [IDW-1:0]      rd_cf_id,
    input  logic [ADDR_W-1:0]   rd_cf_addr,
    input  logic [LEN_W-1:0]    rd_cf_len,
    input  logic [SIZE_W-1:0]   rd_cf_size,
    input  logic [BURST_W-1:0]  rd_cf_burst,
    input  logic [CTXW-1:0]     rd_cf_user,

    output logic                cmd_valid,
    input  logic                cmd_ready,
    output logic                cmd_is_wr,
    output logic [IDW-1:0]      cmd_id,
    output logic [ADDR_W-1:0]   cmd_addr,
    output logic [LEN_W-1:0]    cmd_len,
    output logic [SIZE_W-1:0]   cmd_size,
    output logic [BURST_W-1:0]  cmd_burst,
    output logic [CTXW-1:0]     cmd_user,

    input  logic                credit_return,
    output logic [CREDIT_W-1:0] credit_cnt,
    output logic                credit_err,

    output logic [STAT_W-1:0]   stat_wr_grants,
    output logic [STAT_W-1:0]   stat_rd_grants
);

    localparam logic [CREDIT_W-1:0] CREDIT_MAX = CREDIT_W'(CREDITS);

    state_e      state_q;
    state_e      state_d;
    logic        grant_c;
    logic        pick_wr_c;
    axi_fields_t fields_q;

    // Grant is held off during reset so no FIFO pops while rst_n is low
    assign grant_c = rst_n && (state_q == ST_IDLE) && (credit_cnt != '0)
                     && (!wr_cf_empty || !rd_cf_empty);

    axi_slave_cmd_arb_sel #(
        .WR_WEIGHT (WR_WEIGHT)
    ) u_sel (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_pend   (!wr_cf_empty),
        .rd_pend   (!rd_cf_empty),
        .grant     (grant_c),
        .pick_wr_c (pick_wr_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (grant_c)   state_d = ST_ISSUE;
            ST_ISSUE: if (cmd_ready) state_d = ST_IDLE;
            default:                 state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        wr_cf_rd_en = 1'b0;
        rd_cf_rd_en = 1'b0;
        cmd_valid   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                wr_cf_rd_en = grant_c && pick_wr_c;
                rd_cf_rd_en = grant_c && !pick_wr_c;
            end
            ST_ISSUE: cmd_valid = 1'b1;
            default: ;
        endcase
    end

    // Payload captured from the winner's FWFT head on the popping edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_is_wr <= 1'b0;
            cmd_id    <= '0;
            cmd_user  <= '0;
            fields_q  <= '0;
        end else if (grant_c) begin
            cmd_is_wr <= pick_wr_c;
            cmd_id    <= pick_wr_c ? wr_cf_id : rd_cf_id;
            cmd_user  <= pick_wr_c ? wr_cf_user : rd_cf_user;
            fields_q  <= pick_wr_c
                ? axi_fields_t'{addr: wr_cf_addr, len: wr_cf_len, size: wr_cf_size, burst: wr_cf_burst}
                : axi_fields_t'{addr: rd_cf_addr, len: rd_cf_len, size: rd_cf_size, burst: rd_cf_burst};
        end
    end

    assign cmd_addr  = fields_q.addr;
    assign cmd_len   = fields_q.len;
    assign cmd_size  = fields_q.size;
    assign cmd_burst = fields_q.burst;

    // A return coinciding with a grant cancels out; an excess return is flagged and dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit_cnt <= CREDIT_MAX;
            credit_err <= 1'b0;
        end else if (grant_c && !credit_return) begin
            credit_cnt <= credit_cnt - CREDIT_W'(1);
        end else if (!grant_c && credit_return) begin
            if (credit_cnt == CREDIT_MAX) begin
                credit_err <= 1'b1;
            end else begin
                credit_cnt <= credit_cnt + CREDIT_W'(1);
            end
        end
    end

`ifdef AXI_SLAVE_CMD_ARB_STATS_EN
    logic [STAT_W-1:0] wr_grants_q;
    logic [STAT_W-1:0] rd_grants_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_grants_q <= '0;
            rd_grants_q <= '0;
        end else if (grant_c) begin
            if (pick_wr_c) wr_grants_q <= wr_grants_q + STAT_W'(1);
            else           rd_grants_q <= rd_grants_q + STAT_W'(1);
        end
    end

    assign stat_wr_grants = wr_grants_q;
    assign stat_rd_grants = rd_grants_q;
`else
    assign stat_wr_grants = '0;
    assign stat_rd_grants = '0;
`endif

endmodule

// File: tb/tb_axi_slave_cmd_arb.sv
// Randomized and directed bench for axi_slave_cmd_arb against a queue-based reference model.
module tb_axi_slave_cmd_arb;

    localparam int IDW  = 3;
    localparam int CTXW = 9;
    localparam int WRW  = 2;
    localparam int CR   = 16;

    typedef struct packed {
        logic [IDW-1:0]  id;
        logic [63:0]     addr;
        logic [7:0]      len;
        logic [2:0]      size;
        logic [1:0]      burst;
        logic [CTXW-1:0] user;
    } cmd_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic wr_cf_empty, wr_cf_rd_en, rd_cf_empty, rd_cf_rd_en;
    logic [IDW-1:0] wr_cf_id, rd_cf_id, cmd_id;
    logic [63:0] wr_cf_addr, rd_cf_addr, cmd_addr;
    logic [7:0] wr_cf_len, rd_cf_len, cmd_len, credit_cnt;
    logic [2:0] wr_cf_size, rd_cf_size, cmd_size;
    logic [1:0] wr_cf_burst, rd_cf_burst, cmd_burst;
    logic [CTXW-1:0] wr_cf_user, rd_cf_user, cmd_user;
    logic cmd_valid, cmd_ready, cmd_is_wr, credit_return, credit_err;
    logic [31:0] stat_wr_grants, stat_rd_grants;

    axi_slave_cmd_arb #(.IDW(IDW), .CTXW(CTXW), .WR_WEIGHT(WRW), .CREDITS(CR)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_cf_empty(wr_cf_empty), .wr_cf_rd_en(wr_cf_rd_en), .wr_cf_id(wr_cf_id),
        .wr_cf_addr(wr_cf_addr), .wr_cf_len(wr_cf_len), .wr_cf_size(wr_cf_size),
        .wr_cf_burst(wr_cf_burst), .wr_cf_user(wr_cf_user),
        .rd_cf_empty(rd_cf_empty), .rd_cf_rd_en(rd_cf_rd_en), .rd_cf_id(rd_cf_id),
        .rd_cf_addr(rd_cf_addr), .rd_cf_len(rd_cf_len), .rd_cf_size(rd_cf_size),
        .rd_cf_burst(rd_cf_burst), .rd_cf_user(rd_cf_user),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_is_wr(cmd_is_wr), .cmd_id(cmd_id),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_burst(cmd_burst),
        .cmd_user(cmd_user),
        .credit_return(credit_return), .credit_cnt(credit_cnt), .credit_err(credit_err),
        .stat_wr_grants(stat_wr_grants), .stat_rd_grants(stat_rd_grants)
    );

    always #5 clk = ~clk;

    // Reference model state: FIFO contents plus the transaction-level view of the arbiter
    cmd_t wr_q[$], rd_q[$];
    cmd_t m_cmd;
    bit   m_busy, m_is_wr, m_err;
    int   m_credits, m_wr_run;
    logic [31:0] m_wr_g, m_rd_g;
    bit   g_any, g_wr;
    bit   ready_v, ret_v;

    int   n_vec, n_err, n_hs, n_pop_wr, n_pop_rd;
    bit   hs_log[$];
    bit   exp_seq [0:11] = '{1, 1, 0, 1, 1, 0, 1, 1, 0, 0, 0, 0};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic cmd_t rnd_cmd();
        cmd_t c;
        c.id    = IDW'($urandom);
        c.addr  = {$urandom, $urandom};
        c.len   = 8'($urandom);
        c.size  = 3'($urandom);
        c.burst = 2'($urandom);
        c.user  = CTXW'($urandom);
        return c;
    endfunction

    task automatic drive();
        cmd_t h;
        h = (wr_q.size() != 0) ? wr_q[0] : '0;
        wr_cf_empty = (wr_q.size() == 0);
        {wr_cf_id, wr_cf_addr, wr_cf_len, wr_cf_size, wr_cf_burst, wr_cf_user} = h;
        h = (rd_q.size() != 0) ? rd_q[0] : '0;
        rd_cf_empty = (rd_q.size() == 0);
        {rd_cf_id, rd_cf_addr, rd_cf_len, rd_cf_size, rd_cf_burst, rd_cf_user} = h;
        cmd_ready     = ready_v;
        credit_return = ret_v;
    endtask

    // Decide from the rules which (if any) FIFO is popped this cycle
    task automatic decide();
        bit has_w, has_r;
        has_w = (wr_q.size() != 0);
        has_r = (rd_q.size() != 0);
        g_any = !m_busy && (m_credits > 0) && (has_w || has_r);
        if (has_w && has_r) g_wr = (m_wr_run < WRW);
        else                g_wr = has_w;
    endtask

    task automatic model_reset();
        m_busy = 0; m_is_wr = 0; m_err = 0; m_credits = CR; m_wr_run = 0;
        m_wr_g = '0; m_rd_g = '0; m_cmd = '0;
        wr_q.delete(); rd_q.delete();
    endtask

    task automatic model_advance();
        bit rd_waiting;
        rd_waiting = (rd_q.size() != 0);
        if (m_busy && ready_v) m_busy = 0;
        if (g_any) begin
            m_busy  = 1;
            m_is_wr = g_wr;
            if (g_wr) begin
                m_cmd = wr_q.pop_front();
                m_wr_g++;
                m_wr_run = rd_waiting ? ((m_wr_run + 1 > WRW) ? WRW : m_wr_run + 1) : 0;
            end else begin
                m_cmd = rd_q.pop_front();
                m_rd_g++;
                m_wr_run = 0;
            end
        end
        if (g_any && !ret_v) m_credits--;
        else if (!g_any && ret_v) begin
            if (m_credits == CR) m_err = 1;
            else                 m_credits++;
        end
    endtask

    // One clock: drive, compare every output against the model, advance at the edge
    task automatic step();
        drive();
        #1;
        decide();
        chk("wr_cf_rd_en", 64'(wr_cf_rd_en), 64'(g_any && g_wr));
        chk("rd_cf_rd_en", 64'(rd_cf_rd_en), 64'(g_any && !g_wr));
        chk("cmd_valid", 64'(cmd_valid), 64'(m_busy));
        if (m_busy) begin
            chk("cmd_is_wr", 64'(cmd_is_wr), 64'(m_is_wr));
            chk("cmd_id", 64'(cmd_id), 64'(m_cmd.id));
            chk("cmd_addr", cmd_addr, m_cmd.addr);
            chk("cmd_len", 64'(cmd_len), 64'(m_cmd.len));
            chk("cmd_size", 64'(cmd_size), 64'(m_cmd.size));
            chk("cmd_burst", 64'(cmd_burst), 64'(m_cmd.burst));
            chk("cmd_user", 64'(cmd_user), 64'(m_cmd.user));
        end
        chk("credit_cnt", 64'(credit_cnt), 64'(m_credits));
        chk("credit_err", 64'(credit_err), 64'(m_err));
`ifdef AXI_SLAVE_CMD_ARB_STATS_EN
        chk("stat_wr_grants", 64'(stat_wr_grants), 64'(m_wr_g));
        chk("stat_rd_grants", 64'(stat_rd_grants), 64'(m_rd_g));
`else
        chk("stat_wr_grants", 64'(stat_wr_grants), 64'd0);
        chk("stat_rd_grants", 64'(stat_rd_grants), 64'd0);
`endif
        if (cmd_valid && ready_v) begin
            n_hs++;
            hs_log.push_back(cmd_is_wr);
        end
        if (wr_cf_rd_en) n_pop_wr++;
        if (rd_cf_rd_en) n_pop_rd++;
        @(posedge clk);
        model_advance();
        @(negedge clk);
    endtask

    // Assert reset from a falling edge and check the asynchronous effect before any clock
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst cmd_valid", 64'(cmd_valid), 64'd0);
        chk("rst wr_cf_rd_en", 64'(wr_cf_rd_en), 64'd0);
        chk("rst rd_cf_rd_en", 64'(rd_cf_rd_en), 64'd0);
        chk("rst credit_cnt", 64'(credit_cnt), 64'd16);
        chk("rst credit_err", 64'(credit_err), 64'd0);
        chk("rst cmd_addr", cmd_addr, 64'd0);
        chk("rst cmd_id", 64'(cmd_id), 64'd0);
        chk("rst stat_wr", 64'(stat_wr_grants), 64'd0);
        model_reset();
        ready_v = 0; ret_v = 0;
        drive();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int base;
        n_vec = 0; n_err = 0; n_hs = 0; n_pop_wr = 0; n_pop_rd = 0;
        ready_v = 0; ret_v = 0;
        model_reset();
        drive();
        @(negedge clk);
        do_reset();

        // Idle after reset
        for (int i = 0; i < 100; i++) step();
        chk("idle credit_cnt", 64'(credit_cnt), 64'd16);

        // Weighted interleave with both FIFOs preloaded
        for (int i = 0; i < 6; i++) begin
            wr_q.push_back(rnd_cmd());
            rd_q.push_back(rnd_cmd());
        end
        ready_v = 1;
        hs_log.delete();
        for (int i = 0; i < 30; i++) step();
        chk("seq length", 64'(hs_log.size()), 64'd12);
        for (int i = 0; i < 12; i++) begin
            if (i < hs_log.size()) chk($sformatf("seq[%0d]", i), 64'(hs_log[i]), 64'(exp_seq[i]));
        end
        chk("seq credit_cnt", 64'(credit_cnt), 64'd4);
        do_reset();

        // Credit exhaustion, then a single return releases one more command
        for (int i = 0; i < 20; i++) rd_q.push_back(rnd_cmd());
        ready_v = 1;
        base = n_hs;
        for (int i = 0; i < 50; i++) step();
        chk("exhaust issued", 64'(n_hs - base), 64'd16);
        chk("exhaust credit_cnt", 64'(credit_cnt), 64'd0);
        ret_v = 1; step(); ret_v = 0;
        for (int i = 0; i < 10; i++) step();
        chk("one return issued", 64'(n_hs - base), 64'd17);
        do_reset();

        // Downstream stall holds the command and pops nothing
        wr_q.push_back(rnd_cmd());
        wr_q.push_back(rnd_cmd());
        rd_q.push_back(rnd_cmd());
        ready_v = 0;
        step();
        base = n_pop_wr + n_pop_rd;
        for (int i = 0; i < 20; i++) step();
        chk("stall pops", 64'(n_pop_wr + n_pop_rd - base), 64'd0);
        chk("stall cmd_valid", 64'(cmd_valid), 64'd1);
        ready_v = 1;
        for (int i = 0; i < 10; i++) step();
        do_reset();

        // Excess credit return sets a sticky error
        ret_v = 1; step(); ret_v = 0;
        chk("overflow credit_cnt", 64'(credit_cnt), 64'd16);
        chk("overflow credit_err", 64'(credit_err), 64'd1);
        for (int i = 0; i < 5; i++) step();
        chk("sticky credit_err", 64'(credit_err), 64'd1);
        do_reset();

        // Reset while a command is held downstream
        wr_q.push_back(rnd_cmd());
        ready_v = 0;
        step(); step();
        chk("pre-reset cmd_valid", 64'(cmd_valid), 64'd1);
        do_reset();

        // Grant statistics
        for (int i = 0; i < 7; i++) wr_q.push_back(rnd_cmd());
        for (int i = 0; i < 3; i++) rd_q.push_back(rnd_cmd());
        ready_v = 1;
        for (int i = 0; i < 40; i++) step();
`ifdef AXI_SLAVE_CMD_ARB_STATS_EN
        chk("stat wr total", 64'(stat_wr_grants), 64'd7);
        chk("stat rd total", 64'(stat_rd_grants), 64'd3);
`else
        chk("stat wr total", 64'(stat_wr_grants), 64'd0);
        chk("stat rd total", 64'(stat_rd_grants), 64'd0);
`endif
        do_reset();

        // Randomized traffic with legal credit returns
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 2) == 0 && wr_q.size() < 8) wr_q.push_back(rnd_cmd());
            if ($urandom_range(0, 2) == 0 && rd_q.size() < 8) rd_q.push_back(rnd_cmd());
            ready_v = ($urandom_range(0, 3) != 0);
            ret_v   = (CR - m_credits > 1) && ($urandom_range(0, 1) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
